ldtu_tx_buffer: RTL and testbench
=================================

LDTU_TX_BUFFER -- requirements
Module: ldtu_tx_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 8, FIFO depth in 32-bit words; power of two, at least 4.
REQ-002 SHALL have parameter IDLE_WORD, default 32'hEAAAAAAA, word sent when no data is available.
REQ-003 SHALL have port clk  in  1  clock; all logic on its rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-low reset.
REQ-005 SHALL have port fallback  in  1  mode select: 0 normal encoder stream, 1 fallback stream.
REQ-006 SHALL have port data_in  in  32  normal-mode encoded word.
REQ-007 SHALL have port load  in  1  data_in valid, single-cycle qualifier.
REQ-008 SHALL have port data_in_fb  in  32  fallback-mode encoded word.
REQ-009 SHALL have port load_fb  in  1  data_in_fb valid, single-cycle qualifier.
REQ-010 SHALL have port tx_req  in  1  serializer request for the next word.
REQ-011 SHALL have port ovf_clr  in  1  clears the overflow status.
REQ-012 SHALL have port tx_word  out  32  word presented to the serializer.
REQ-013 SHALL have port tx_is_idle  out  1  high when tx_word is IDLE_WORD filler.
REQ-014 SHALL have port fill_level  out  log2(DEPTH)+1  current FIFO occupancy.
REQ-015 SHALL have port overflow  out  1  sticky flag, set when a word is dropped.
REQ-016 SHALL have port ovf_count  out  8  count of dropped words, saturating.

Function
REQ-017 SHALL run an FSM with states RUN_N, FLUSH and RUN_FB, plus a registered copy fallback_q.
REQ-018 SHALL select the write source as data_in/load in RUN_N and data_in_fb/load_fb in RUN_FB; the other stream is ignored.
REQ-019 SHALL move to FLUSH in any RUN state in the cycle where fallback != fallback_q, and SHALL ignore both load inputs in that cycle.
REQ-020 SHALL in FLUSH, for exactly one cycle: zero the read/write pointers and fill_level, ignore writes, answer tx_req with IDLE_WORD, then enter RUN_N if fallback=0 or RUN_FB if fallback=1.
REQ-021 SHALL write the selected word at the write pointer when the selected load=1 and the FIFO is not full; fill_level increments by 1 on the next edge.
REQ-022 SHALL, when the selected load=1 and the FIFO is full with no read that cycle, drop the word: overflow<=1 and ovf_count increments, saturating at 255.
REQ-023 SHALL, when tx_req=1 in cycle N, update tx_word at the edge ending cycle N (1-cycle latency): the head word with tx_is_idle<=0 if fill_level>0, otherwise IDLE_WORD with tx_is_idle<=1.
REQ-024 SHALL hold tx_word and tx_is_idle unchanged while tx_req=0.
REQ-025 SHALL, on a simultaneous read and write with the FIFO full, accept the write with no overflow and leave fill_level unchanged.
REQ-026 SHALL, on a simultaneous read and write with the FIFO empty, output IDLE_WORD (no bypass path), store the word and set fill_level to 1.
REQ-027 SHALL wrap both pointers modulo DEPTH; full is fill_level==DEPTH and empty is fill_level==0.
REQ-028 SHALL, on ovf_clr=1, set overflow<=0 and ovf_count<=0; if a drop occurs in the same cycle, the drop wins: overflow<=1 and ovf_count<=1.
REQ-029 SHALL let the overflow status survive FLUSH; only reset or ovf_clr clear it.
REQ-030 SHALL drive every output from a register; no combinational path from any input to any output.

Reset
REQ-031 SHALL, with reset=0 at a rising edge, set state to RUN_N, fallback_q<=0, pointers<=0, fill_level<=0, tx_word<=IDLE_WORD, tx_is_idle<=1, overflow<=0, ovf_count<=0.
REQ-032 SHALL not clear FIFO RAM contents on reset; pointers alone define validity.
REQ-033 SHALL, if fallback=1 at reset release, perform one FLUSH cycle and then enter RUN_FB.
REQ-034 SHALL, on reset asserted mid-operation, discard all stored words and output IDLE_WORD on the next tx_req.

Verification
REQ-035 SHALL cover normal flow: load words 0x11111111 and 0x22222222, then two tx_req -> tx_word=0x11111111 then 0x22222222, tx_is_idle=0, fill_level returns to 0.
REQ-036 SHALL cover underrun: tx_req with the FIFO empty -> tx_word=0xEAAAAAAA, tx_is_idle=1.
REQ-037 SHALL cover overflow: 10 loads with no tx_req at DEPTH=8 -> fill_level=8, overflow=1, ovf_count=2; the first 8 words are read back in order.
REQ-038 SHALL cover mode switch: 3 words queued, fallback 0->1 -> one FLUSH cycle, fill_level=0, next tx_req gives IDLE_WORD; a subsequent load_fb word 0xF0000ABC is read back correctly.
REQ-039 SHALL cover full with simultaneous read and write: no overflow, fill_level stays 8, data order preserved.
REQ-040 SHALL cover saturation and clear: 300 drops -> ovf_count=255; ovf_clr together with a drop -> ovf_count=1, overflow=1.

Source files
------------

// File: rtl/ldtu_tx_if.sv
// LDTU transmit buffer bus: both write streams,
// serializer request side and status outputs.
interface ldtu_tx_if #(
   parameter int DEPTH = 8
);
   logic                     fallback;
   logic [31:0]              data_in;
   logic                     load;
   logic [31:0]              data_in_fb;
   logic                     load_fb;
   logic                     tx_req;
   logic                     ovf_clr;
   logic [31:0]              tx_word;
   logic                     tx_is_idle;
   logic [$clog2(DEPTH):0]   fill_level;
   logic                     overflow;
   logic [7:0]               ovf_count;

   modport master (
      output fallback, data_in, load,
      output data_in_fb, load_fb,
      output tx_req, ovf_clr,
      input  tx_word, tx_is_idle,
      input  fill_level, overflow, ovf_count
   );

   modport slave (
      input  fallback, data_in, load,
      input  data_in_fb, load_fb,
      input  tx_req, ovf_clr,
      output tx_word, tx_is_idle,
      output fill_level, overflow, ovf_count
   );
endinterface

// File: rtl/ldtu_tx_buffer.sv
// LDTU transmit FIFO between encoder and serializer;
// a mode change flushes the queue and fills with IDLE.
module ldtu_tx_buffer #(
   parameter int          DEPTH     = 8,
   parameter logic [31:0] IDLE_WORD = 32'hEAAAAAAA
) (
   input  logic      clk,
   input  logic      reset,
   ldtu_tx_if.slave  bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {
      RUN_N  = 2'd0,
      FLUSH  = 2'd1,
      RUN_FB = 2'd2
   } state_t;

   state_t         state, state_n;
   logic           fallback_q;
   logic [AW-1:0]  wptr, rptr;
   logic [CW-1:0]  cnt, cnt_n;
   logic [31:0]    mem [DEPTH];
   logic [31:0]    tx_word_q;
   logic           tx_idle_q;
   logic           ovf_q;
   logic [7:0]     ovf_cnt_q;

   logic           flush, sel_load, wr_en, rd_en, drop;
   logic           full, empty;
   logic [31:0]    sel_data;

   assign full  = (cnt == CW'(DEPTH));
   assign empty = (cnt == '0);

   always_ff @(posedge clk) begin
      if (!reset) state <= RUN_N;
      else        state <= state_n;
   end

   always_comb begin
      state_n  = state;
      flush    = 1'b0;
      sel_load = 1'b0;
      sel_data = bus.data_in;
      unique case (state)
         RUN_N: begin
            sel_load = bus.load;
            sel_data = bus.data_in;
         end
         RUN_FB: begin
            sel_load = bus.load_fb;
            sel_data = bus.data_in_fb;
         end
         FLUSH: begin
            flush   = 1'b1;
            state_n = bus.fallback ? RUN_FB : RUN_N;
         end
         default: state_n = RUN_N;
      endcase
      // A mode edge discards whatever either stream offers this cycle
      if (state != FLUSH && bus.fallback != fallback_q) begin
         state_n  = FLUSH;
         sel_load = 1'b0;
      end
      rd_en = !flush && bus.tx_req && !empty;
      wr_en = sel_load && (!full || rd_en);
      drop  = sel_load && full && !rd_en;
      cnt_n = cnt + CW'(wr_en) - CW'(rd_en);
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[wptr] <= sel_data;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         fallback_q <= 1'b0;
         wptr       <= '0;
         rptr       <= '0;
         cnt        <= '0;
         tx_word_q  <= IDLE_WORD;
         tx_idle_q  <= 1'b1;
         ovf_q      <= 1'b0;
         ovf_cnt_q  <= '0;
      end else begin
         fallback_q <= bus.fallback;
         if (flush) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
         end else begin
            if (wr_en) wptr <= wptr + AW'(1);
            if (rd_en) rptr <= rptr + AW'(1);
            cnt <= cnt_n;
         end
         if (bus.tx_req) begin
            if (rd_en) begin
               tx_word_q <= mem[rptr];
               tx_idle_q <= 1'b0;
            end else begin
               tx_word_q <= IDLE_WORD;
               tx_idle_q <= 1'b1;
            end
         end
         // A drop outranks a clear in the same cycle
         if (drop) begin
            ovf_q <= 1'b1;
            if (bus.ovf_clr)
               ovf_cnt_q <= 8'd1;
            else if (ovf_cnt_q != 8'hFF)
               ovf_cnt_q <= ovf_cnt_q + 8'd1;
         end else if (bus.ovf_clr) begin
            ovf_q     <= 1'b0;
            ovf_cnt_q <= '0;
         end
      end
   end

   assign bus.tx_word    = tx_word_q;
   assign bus.tx_is_idle = tx_idle_q;
   assign bus.fill_level = cnt;
   assign bus.overflow   = ovf_q;
   assign bus.ovf_count  = ovf_cnt_q;
endmodule

// File: tb/tb_ldtu_tx_buffer.sv
// Scoreboard bench for ldtu_tx_buffer: requests queue
// expected words, a monitor checks them after each edge.
module tb_ldtu_tx_buffer;
   localparam int          DEPTH = 8;
   localparam logic [31:0] IDLE  = 32'hEAAAAAAA;

   typedef struct {
      logic [31:0] w;
      logic        idle;
   } exp_t;

   logic clk;
   logic reset;
   int   checks = 0;
   int   passed = 0;
   exp_t exp_q[$];

   ldtu_tx_if #(.DEPTH(DEPTH)) bus ();

   ldtu_tx_buffer #(.DEPTH(DEPTH), .IDLE_WORD(IDLE)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   always @(posedge clk) begin
      if (bus.tx_req === 1'b1 && reset === 1'b1) begin
         #1;
         if (exp_q.size() == 0) begin
            checks++;
            $display("FAIL unexpected_tx: got %h with empty scoreboard",
                     bus.tx_word);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("tx_word", bus.tx_word, e.w);
            chk("tx_is_idle", 32'(bus.tx_is_idle), 32'(e.idle));
         end
      end
   end

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic ld_n(input logic [31:0] w);
      bus.load    = 1'b1;
      bus.data_in = w;
      cyc();
      bus.load    = 1'b0;
   endtask

   task automatic ld_fb(input logic [31:0] w);
      bus.load_fb    = 1'b1;
      bus.data_in_fb = w;
      cyc();
      bus.load_fb    = 1'b0;
   endtask

   task automatic req(input logic [31:0] w, input logic idle);
      exp_t e;
      e.w    = w;
      e.idle = idle;
      exp_q.push_back(e);
      bus.tx_req = 1'b1;
      cyc();
      bus.tx_req = 1'b0;
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_tx_word"}, bus.tx_word, IDLE);
      chk({tag, "_idle"}, 32'(bus.tx_is_idle), 32'd1);
      chk({tag, "_fill"}, 32'(bus.fill_level), 32'd0);
      chk({tag, "_ovf"}, 32'(bus.overflow), 32'd0);
      chk({tag, "_ovf_cnt"}, 32'(bus.ovf_count), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset          = 1'b0;
      bus.fallback   = 1'b0;
      bus.data_in    = '0;
      bus.load       = 1'b0;
      bus.data_in_fb = '0;
      bus.load_fb    = 1'b0;
      bus.tx_req     = 1'b0;
      bus.ovf_clr    = 1'b0;
      repeat (2) cyc();
      chk_reset_state("rst");
      reset = 1'b1;
      cyc();

      // normal flow
      ld_n(32'h11111111);
      ld_n(32'h22222222);
      chk("nf_fill2", 32'(bus.fill_level), 32'd2);
      req(32'h11111111, 1'b0);
      req(32'h22222222, 1'b0);
      chk("nf_fill0", 32'(bus.fill_level), 32'd0);

      // underrun, then tx_word held while idle
      req(IDLE, 1'b1);
      cyc();
      chk("hold_word", bus.tx_word, IDLE);

      // overflow: 10 loads into 8 slots
      for (int i = 0; i < 10; i++) ld_n(32'hA0000000 + 32'(i));
      chk("ov_fill", 32'(bus.fill_level), 32'd8);
      chk("ov_flag", 32'(bus.overflow), 32'd1);
      chk("ov_cnt", 32'(bus.ovf_count), 32'd2);
      for (int i = 0; i < 8; i++) req(32'hA0000000 + 32'(i), 1'b0);
      chk("ov_drain", 32'(bus.fill_level), 32'd0);
      req(IDLE, 1'b1);
      bus.ovf_clr = 1'b1;
      cyc();
      bus.ovf_clr = 1'b0;
      chk("clr_flag", 32'(bus.overflow), 32'd0);
      chk("clr_cnt", 32'(bus.ovf_count), 32'd0);

      // full with simultaneous read and write
      for (int i = 0; i < 8; i++) ld_n(32'hB0000000 + 32'(i));
      bus.load    = 1'b1;
      bus.data_in = 32'hB0000008;
      req(32'hB0000000, 1'b0);
      bus.load    = 1'b0;
      chk("rw_fill", 32'(bus.fill_level), 32'd8);
      chk("rw_ovf", 32'(bus.overflow), 32'd0);
      for (int i = 1; i <= 8; i++) req(32'hB0000000 + 32'(i), 1'b0);

      // empty with simultaneous read and write: no bypass
      bus.load    = 1'b1;
      bus.data_in = 32'h5A5A0001;
      req(IDLE, 1'b1);
      bus.load    = 1'b0;
      chk("rwe_fill", 32'(bus.fill_level), 32'd1);
      req(32'h5A5A0001, 1'b0);

      // mode switch 0->1 with 3 words queued
      for (int i = 0; i < 3; i++) ld_n(32'hC0000000 + 32'(i));
      bus.fallback = 1'b1;
      bus.load     = 1'b1;
      bus.data_in  = 32'hDEADDEAD;
      cyc();
      bus.load     = 1'b0;
      req(IDLE, 1'b1);
      chk("ms_fill", 32'(bus.fill_level), 32'd0);
      req(IDLE, 1'b1);
      bus.load    = 1'b1;
      bus.data_in = 32'h12345678;
      ld_fb(32'hF0000ABC);
      bus.load    = 1'b0;
      chk("ms_fill1", 32'(bus.fill_level), 32'd1);
      req(32'hF0000ABC, 1'b0);

      // saturation and clear-with-drop
      for (int i = 0; i < 8; i++) ld_fb(32'hD0000000 + 32'(i));
      bus.load_fb = 1'b1;
      repeat (300) cyc();
      chk("sat_cnt", 32'(bus.ovf_count), 32'd255);
      chk("sat_flag", 32'(bus.overflow), 32'd1);
      bus.ovf_clr = 1'b1;
      cyc();
      bus.ovf_clr = 1'b0;
      bus.load_fb = 1'b0;
      chk("clrdrop_cnt", 32'(bus.ovf_count), 32'd1);
      chk("clrdrop_flag", 32'(bus.overflow), 32'd1);
      req(32'hD0000000, 1'b0);

      // reset mid-operation with fallback held high
      reset = 1'b0;
      cyc();
      chk_reset_state("mrst");
      reset = 1'b1;
      req(IDLE, 1'b1);
      cyc();
      ld_fb(32'hE1E1E1E1);
      chk("mrst_fill", 32'(bus.fill_level), 32'd1);
      req(32'hE1E1E1E1, 1'b0);

      repeat (3) cyc();
      checks++;
      if (exp_q.size() == 0) passed++;
      else $display("FAIL scoreboard_drain: got %0d pending expected 0",
                    exp_q.size());
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
